pwm_multi: RTL and testbench

- Multi-channel PWM generator. One shared period counter drives CHANNELS compare channels.
- Period, duty and mode are double-buffered. Shadow registers update only at a period boundary, via a req/ack handshake.
- Supports edge-aligned and center-aligned modes and per-channel output polarity.
- Sits between the host register interface and the pads; successor to the single-channel 4-bit PWM.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_multi_channel.sv | 53 +++++
 rtl/pwm_multi.sv | 132 +++++++++++++
 tb/tb_pwm_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the multi-channel PWM block.
//   pwm_mode_e : edge-aligned / center-aligned counting mode
//   pwm_dir_e  : counter direction, only meaningful in center mode
//   PWM_WIDTH  : default counter/period/duty width
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 8;

  typedef enum logic {
    PWM_MODE_EDGE   = 1'b0,
    PWM_MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_channel.sv
// pwm_channel: one compare channel of pwm_multi.
// Holds the duty shadow register, compares it against the counter value that
// will be present after the current edge, and registers the polarity-adjusted
// output so pwm_out lines up with count with no lag.
// Ports:
//   clock, resetPWM : rising-edge clock, async active-high reset
//   capture         : shadow update strobe from the top-level handshake
//   duty_in         : this channel's new duty value
//   count_nxt       : counter value after this edge
//   run             : enable as sampled on this edge; 0 forces inactive
//   pzero           : period will be 0 after this edge; forces inactive
//   pwm_out         : registered output, POLARITY when inactive
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH,
  parameter logic        POLARITY = 1'b0
) (
  input  logic             clock,
  input  logic             resetPWM,
  input  logic             capture,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [WIDTH-1:0] count_nxt,
  input  logic             run,
  input  logic             pzero,
  output logic             pwm_out
);

  logic [WIDTH-1:0] r_duty_sh;
  logic [WIDTH-1:0] w_duty_nxt;
  logic             w_active;
  logic             r_pwm;

  // The compare uses the post-edge duty so a newly captured value takes
  // effect on the very first cycle of the new period.
  always_comb begin
    w_duty_nxt = capture ? duty_in : r_duty_sh;
    w_active   = run && !pzero && (count_nxt < w_duty_nxt);
  end

  always_ff @(posedge clock or posedge resetPWM) begin
    if (resetPWM) begin
      r_duty_sh <= '0;
      r_pwm     <= POLARITY;
    end else begin
      r_duty_sh <= w_duty_nxt;
      r_pwm     <= w_active ^ POLARITY;
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator.
// One shared period counter (edge- or center-aligned) drives CHANNELS compare
// channels. Period, duty and mode are double-buffered; shadows are reloaded
// only at a period boundary (or at once while disabled) through a level
// load_req / one-cycle load_ack handshake.
// Ports:
//   clock      : rising-edge clock
//   resetPWM   : asynchronous, active-high reset
//   enable     : run/stop level; 0 holds count at 0 and outputs inactive
//   load_req   : host request to capture period_in/duty_in/mode_in
//   load_ack   : one-cycle pulse during the first cycle after capture
//   mode_in    : 0 = edge-aligned, 1 = center-aligned
//   period_in  : new period P
//   duty_in    : new duties, channel i in [i*WIDTH +: WIDTH]
//   count      : current counter value
//   period_end : high during the boundary cycle while enabled
//   pwm_out    : registered PWM outputs (POLARITY bit set = active-low)
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned          CHANNELS       = 4,
  parameter int unsigned          WIDTH          = PWM_WIDTH,
  parameter logic [WIDTH-1:0]     DEFAULT_PERIOD = WIDTH'(10),
  parameter logic [CHANNELS-1:0]  POLARITY       = '0
) (
  input  logic                      clock,
  input  logic                      resetPWM,
  input  logic                      enable,
  input  logic                      load_req,
  output logic                      load_ack,
  input  logic                      mode_in,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [WIDTH-1:0]          count,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       pwm_out
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period_sh;
  pwm_dir_e         r_dir;
  pwm_mode_e        r_mode_sh;
  logic             r_load_ack;

  logic [WIDTH-1:0] w_count_nxt;
  pwm_dir_e         w_dir_nxt;
  logic [WIDTH-1:0] w_last;
  logic             w_pzero;
  logic             w_pzero_nxt;
  logic             w_boundary;
  logic             w_capture;

  always_comb begin
    w_pzero  = (r_period_sh == '0);
    w_last   = r_period_sh - WIDTH'(1);

    // P==0 reports a boundary every cycle so a reload can always get in.
    if (w_pzero) begin
      w_boundary = 1'b1;
    end else if (r_mode_sh == PWM_MODE_EDGE) begin
      w_boundary = (r_count == w_last);
    end else begin
      w_boundary = (r_count == '0) && (r_dir == DIR_DOWN);
    end

    w_capture = load_req && (!enable || w_boundary);

    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    if (!enable || w_capture || w_pzero) begin
      w_count_nxt = '0;
      w_dir_nxt   = DIR_UP;
    end else if (r_mode_sh == PWM_MODE_EDGE) begin
      w_count_nxt = (r_count == w_last) ? '0 : r_count + WIDTH'(1);
      w_dir_nxt   = DIR_UP;
    end else if (r_dir == DIR_UP) begin
      // Center mode dwells one extra cycle at each end while turning round.
      if (r_count == w_last) begin
        w_dir_nxt = DIR_DOWN;
      end else begin
        w_count_nxt = r_count + WIDTH'(1);
      end
    end else begin
      if (r_count == '0) begin
        w_dir_nxt = DIR_UP;
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
      end
    end

    w_pzero_nxt = w_capture ? (period_in == '0) : w_pzero;
  end

  always_ff @(posedge clock or posedge resetPWM) begin
    if (resetPWM) begin
      r_count     <= '0;
      r_dir       <= DIR_UP;
      r_period_sh <= DEFAULT_PERIOD;
      r_mode_sh   <= PWM_MODE_EDGE;
      r_load_ack  <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_dir      <= w_dir_nxt;
      r_load_ack <= w_capture;
      if (w_capture) begin
        r_period_sh <= period_in;
        r_mode_sh   <= pwm_mode_e'(mode_in);
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    pwm_channel #(
      .WIDTH    (WIDTH),
      .POLARITY (POLARITY[gi])
    ) u_ch (
      .clock     (clock),
      .resetPWM  (resetPWM),
      .capture   (w_capture),
      .duty_in   (duty_in[gi*WIDTH +: WIDTH]),
      .count_nxt (w_count_nxt),
      .run       (enable),
      .pzero     (w_pzero_nxt),
      .pwm_out   (pwm_out[gi])
    );
  end

  assign count      = r_count;
  assign load_ack   = r_load_ack;
  assign period_end = enable && w_boundary;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

  logic        clock = 1'b0;
  logic        resetPWM;
  logic        enable;
  logic        load_req;
  logic        load_ack;
  logic        mode_in;
  logic [7:0]  period_in;
  logic [31:0] duty_in;
  logic [7:0]  count;
  logic        period_end;
  logic [3:0]  pwm_out;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  pwm_multi #(
    .CHANNELS       (4),
    .WIDTH          (8),
    .DEFAULT_PERIOD (8'd10),
    .POLARITY       (4'b0010)
  ) dut (
    .clock      (clock),
    .resetPWM   (resetPWM),
    .enable     (enable),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .mode_in    (mode_in),
    .period_in  (period_in),
    .duty_in    (duty_in),
    .count      (count),
    .period_end (period_end),
    .pwm_out    (pwm_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_load(input logic [7:0] p, input logic m, input logic [7:0] d3,
                          input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    period_in = p;
    mode_in   = m;
    duty_in   = {d3, d2, d1, d0};
    load_req  = 1'b1;
  endtask

  // Advance until period_end is seen at a sample point, bounded.
  task automatic wait_boundary();
    for (int n = 0; n < 40 && !period_end; n++) step();
    check("wait_boundary", period_end, 1'b1);
  endtask

  initial begin
    logic [7:0] cseq [8];
    int unsigned act [4];
    cseq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};

    resetPWM  = 1'b1;
    enable    = 1'b0;
    load_req  = 1'b0;
    mode_in   = 1'b0;
    period_in = '0;
    duty_in   = '0;
    step();
    check("rst_count", count, 8'd0);
    check("rst_pwm", pwm_out, 4'b0010);
    check("rst_ack", load_ack, 1'b0);
    check("rst_pend", period_end, 1'b0);

    // Default period 10, all duties 0.
    resetPWM = 1'b0;
    enable   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("dflt_count", count, 8'(i % 10));
      check("dflt_pend", period_end, (i % 10) == 9);
      if (i > 0) check("dflt_pwm", pwm_out, 4'b0010);
      step();
    end

    // Edge load P=10, D={0,3,10,12} requested at count 4.
    for (int i = 0; i < 4; i++) step();
    set_load(8'd10, 1'b0, 8'd12, 8'd10, 8'd3, 8'd0);
    for (int k = 4; k < 9; k++) begin
      check("B_wait_count", count, 8'(k));
      check("B_wait_ack", load_ack, 1'b0);
      step();
    end
    check("B_bnd_count", count, 8'd9);
    check("B_bnd_pend", period_end, 1'b1);
    step();
    for (int c = 0; c < 4; c++) act[c] = 0;
    for (int i = 0; i < 10; i++) begin
      check("B_count", count, 8'(i));
      check("B_ack", load_ack, i == 0);
      check("B_pwm", pwm_out, {1'b1, 1'b1, !(i < 3), 1'b0});
      for (int c = 0; c < 4; c++) if (pwm_out[c] ^ (c == 1)) act[c]++;
      if (i == 0) load_req = 1'b0;
      step();
    end
    check("B_act0", act[0], 0);
    check("B_act1", act[1], 3);
    check("B_act2", act[2], 10);
    check("B_act3", act[3], 10);

    // Center mode P=4, D0=2.
    set_load(8'd4, 1'b1, 8'd0, 8'd0, 8'd0, 8'd2);
    wait_boundary();
    check("C_bnd_count", count, 8'd9);
    step();
    for (int i = 0; i < 16; i++) begin
      check("C_count", count, cseq[i % 8]);
      check("C_pend", period_end, (i % 8) == 7);
      check("C_ack", load_ack, i == 0);
      check("C_pwm", pwm_out, {1'b0, 1'b0, 1'b1, (cseq[i % 8] < 8'd2)});
      if (i == 0) load_req = 1'b0;
      step();
    end

    // Active-low channel 1, D1=5, P=10.
    set_load(8'd10, 1'b0, 8'd0, 8'd0, 8'd5, 8'd0);
    wait_boundary();
    check("D_bnd_count", count, 8'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("D_count", count, 8'(i));
      check("D_pwm", pwm_out, {2'b00, (i >= 5), 1'b0});
      if (i == 0) load_req = 1'b0;
      step();
    end

    // Drop enable at count 6, load while disabled, re-enable.
    for (int i = 0; i < 6; i++) step();
    check("E_count6", count, 8'd6);
    enable = 1'b0;
    step();
    check("E_dis_count", count, 8'd0);
    check("E_dis_pwm", pwm_out, 4'b0010);
    check("E_dis_pend", period_end, 1'b0);
    set_load(8'd5, 1'b0, 8'd0, 8'd0, 8'd0, 8'd2);
    check("E_ack_pre", load_ack, 1'b0);
    step();
    check("E_ack", load_ack, 1'b1);
    check("E_ack_count", count, 8'd0);
    load_req = 1'b0;
    step();
    check("E_ack_gone", load_ack, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("E_count", count, 8'(i % 5));
      if (i > 0) check("E_pwm", pwm_out, {2'b00, 1'b1, ((i % 5) < 2)});
      step();
    end

    // P=0 holds everything, then escape with P=5, D0=2.
    set_load(8'd0, 1'b0, 8'd0, 8'd0, 8'd5, 8'd2);
    wait_boundary();
    step();
    check("F_ack", load_ack, 1'b1);
    load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("F_count", count, 8'd0);
      check("F_pend", period_end, 1'b1);
      check("F_pwm", pwm_out, 4'b0010);
      step();
    end
    set_load(8'd5, 1'b0, 8'd0, 8'd0, 8'd0, 8'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      check("F2_count", count, 8'(i));
      check("F2_ack", load_ack, i == 0);
      check("F2_pend", period_end, i == 4);
      check("F2_pwm", pwm_out, {2'b00, 1'b1, (i < 2)});
      if (i == 0) load_req = 1'b0;
      step();
    end

    // Async reset mid-period, between clock edges.
    step();
    check("G_pre_pwm", pwm_out, 4'b0011);
    resetPWM = 1'b1;
    #1;
    check("G_rst_count", count, 8'd0);
    check("G_rst_pwm", pwm_out, 4'b0010);
    check("G_rst_pend", period_end, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
